// File: rtl/adc_spi_capture.sv
// LTC1407A capture: a rising edge on enable_adc pulses ad_conv, clocks one 34-bit SPI frame
// and presents two signed samples with a one-cycle data_valid. Optional: ADC_OVR_DETECT_EN.
module adc_spi_capture #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 2,
  parameter int DATA_W      = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_adc,
  input  logic              spi_miso,
  output logic              ad_conv,
  output logic              spi_sck,
  output logic              busy,
  output logic [DATA_W-1:0] ch0_data,
  output logic [DATA_W-1:0] ch1_data,
  output logic              data_valid,
  output logic [1:0]        ovr_flag
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);

  // Frame layout: 2 pad bits, ch0, 2 pad bits, ch1, 2 pad bits.
  localparam logic [5:0] LAST_BIT  = 6'd33;
  localparam logic [5:0] CH0_FIRST = 6'd2;
  localparam logic [5:0] CH0_LAST  = 6'(2 + DATA_W - 1);
  localparam logic [5:0] CH1_FIRST = 6'(2 + DATA_W + 2);
  localparam logic [5:0] CH1_LAST  = 6'(2 + DATA_W + 2 + DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic              enable_adc_q;
  logic              start;
  logic [CONV_W-1:0] conv_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic              sck_q;
  logic [DATA_W-1:0] sh0;
  logic [DATA_W-1:0] sh1;

  logic conv_end;
  logic div_end;
  logic sample;
  logic frame_end;

  assign start     = enable_adc & ~enable_adc_q;
  assign conv_end  = (conv_cnt == CONV_LAST);
  assign div_end   = (div_cnt == DIV_LAST);
  assign sample    = (state == S_SHIFT) && div_end && !sck_q;
  assign frame_end = (state == S_SHIFT) && div_end && sck_q && (bit_cnt == LAST_BIT);

  assign spi_sck = sck_q;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    ad_conv    = 1'b0;
    busy       = 1'b0;
    data_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CONV;
      end
      S_CONV: begin
        ad_conv = 1'b1;
        busy    = 1'b1;
        if (conv_end) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (frame_end) state_nx = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        data_valid = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      enable_adc_q <= 1'b0;
      conv_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sck_q        <= 1'b0;
      sh0          <= '0;
      sh1          <= '0;
      ch0_data     <= '0;
      ch1_data     <= '0;
    end else begin
      enable_adc_q <= enable_adc;
      case (state)
        S_IDLE: begin
          conv_cnt <= '0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          sck_q    <= 1'b0;
          sh0      <= '0;
          sh1      <= '0;
        end
        S_CONV: begin
          conv_cnt <= conv_end ? '0 : conv_cnt + CONV_W'(1);
        end
        S_SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
            if (sck_q) bit_cnt <= bit_cnt + 6'd1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
          // Sample on the clock where SCK rises; pad bits are simply skipped.
          if (sample) begin
            if (bit_cnt >= CH0_FIRST && bit_cnt <= CH0_LAST)
              sh0 <= {sh0[DATA_W-2:0], spi_miso};
            if (bit_cnt >= CH1_FIRST && bit_cnt <= CH1_LAST)
              sh1 <= {sh1[DATA_W-2:0], spi_miso};
          end
        end
        default: ;
      endcase
      // Outputs change only on a completed frame, so partial frames never leak.
      if (frame_end) begin
        ch0_data <= sh0;
        ch1_data <= sh1;
      end
    end
  end

`ifdef ADC_OVR_DETECT_EN
  localparam logic [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_FS = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic at_full_scale(input logic [DATA_W-1:0] s);
    return (s == POS_FS) || (s == NEG_FS);
  endfunction

  logic [1:0] ovr_q;

  always_ff @(posedge clock) begin
    if (reset)          ovr_q <= 2'b00;
    else if (frame_end) ovr_q <= {at_full_scale(sh1), at_full_scale(sh0)};
  end

  assign ovr_flag = ovr_q;
`else
  assign ovr_flag = 2'b00;
`endif

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: default instance plus a CLK_DIV=1/CONV_CYCLES=1 instance,
// each fed by a behavioural LTC1407A serial model.
module tb_adc_spi_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        en_a = 1'b0, miso_a = 1'b0;
  logic        ad_conv_a, sck_a, busy_a, dv_a;
  logic [13:0] ch0_a, ch1_a;
  logic [1:0]  ovr_a;

  logic        en_b = 1'b0, miso_b = 1'b0;
  logic        ad_conv_b, sck_b, busy_b, dv_b;
  logic [13:0] ch0_b, ch1_b;
  logic [1:0]  ovr_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  adc_spi_capture dut_a (
    .clock(clock), .reset(reset), .enable_adc(en_a), .spi_miso(miso_a),
    .ad_conv(ad_conv_a), .spi_sck(sck_a), .busy(busy_a),
    .ch0_data(ch0_a), .ch1_data(ch1_a), .data_valid(dv_a), .ovr_flag(ovr_a)
  );

  adc_spi_capture #(.CLK_DIV(1), .CONV_CYCLES(1), .DATA_W(14)) dut_b (
    .clock(clock), .reset(reset), .enable_adc(en_b), .spi_miso(miso_b),
    .ad_conv(ad_conv_b), .spi_sck(sck_b), .busy(busy_b),
    .ch0_data(ch0_b), .ch1_data(ch1_b), .data_valid(dv_b), .ovr_flag(ovr_b)
  );

  // ADC model: first bit after ad_conv falls, next bit after each SCK fall.
  // Pad bits are driven as ones so any pad leaking into a sample shows up.
  logic [33:0] frame_a, frame_b;
  int idx_a, idx_b;
  int sck_pulses_a = 0;

  function automatic logic [33:0] mk_frame(input logic [13:0] c0, input logic [13:0] c1);
    return {2'b11, c0, 2'b11, c1, 2'b11};
  endfunction

  always @(negedge ad_conv_a) begin idx_a = 0; miso_a = frame_a[33]; end
  always @(negedge sck_a) begin
    idx_a = idx_a + 1;
    if (idx_a < 34) miso_a = frame_a[33-idx_a];
  end
  always @(posedge sck_a) sck_pulses_a = sck_pulses_a + 1;

  always @(negedge ad_conv_b) begin idx_b = 0; miso_b = frame_b[33]; end
  always @(negedge sck_b) begin
    idx_b = idx_b + 1;
    if (idx_b < 34) miso_b = frame_b[33-idx_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Results of the last run_a call.
  int          lat_a, nval_a, conv_hi_a, conv_first_a;
  logic [13:0] got0_a, got1_a;
  logic [1:0]  got_ovr_a;

  // Latency is the edge on which a consumer captures data_valid, counting
  // the edge right after enable_adc rises as T+1.
  task automatic run_a(input logic [13:0] c0, input logic [13:0] c1,
                       input int hold, input int on2, input int off2, input int budget);
    frame_a = mk_frame(c0, c1);
    sck_pulses_a = 0;
    lat_a = -1; nval_a = 0; conv_hi_a = 0; conv_first_a = -1;
    got0_a = 'x; got1_a = 'x; got_ovr_a = 'x;
    @(negedge clock);
    en_a = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clock);
      @(negedge clock);
      en_a = (cyc < hold) || (cyc >= on2 && cyc < off2);
      if (ad_conv_a) begin
        conv_hi_a++;
        if (conv_first_a < 0) conv_first_a = cyc;
      end
      if (dv_a) begin
        nval_a++;
        if (lat_a < 0) begin
          lat_a = cyc + 1; got0_a = ch0_a; got1_a = ch1_a; got_ovr_a = ovr_a;
        end
      end
    end
  endtask

  initial begin
    int dv_seen;
    int lat_b [3];
    logic [13:0] b0 [3];
    logic [13:0] b1 [3];
    int nval_b;
    logic [1:0] exp_ovr1, exp_ovr2;

    frame_a = '0;
    frame_b = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ctrl", {28'd0, ad_conv_a, sck_a, busy_a, dv_a}, 32'd0);
    check("rst_ch0", 32'(ch0_a), 32'd0);
    check("rst_ch1", 32'(ch1_a), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic frame at defaults: 1+2+68*2+1 = 140
    run_a(14'h2AAA, 14'h1555, 20, 0, 0, 200);
    check("t2_latency", 32'(lat_a), 32'd140);
    check("t2_nvalid", 32'(nval_a), 32'd1);
    check("t2_ch0", 32'(got0_a), 32'h2AAA);
    check("t2_ch1", 32'(got1_a), 32'h1555);
    check("t2_sck_pulses", 32'(sck_pulses_a), 32'd34);
    check("t2_conv_first", 32'(conv_first_a), 32'd1);
    check("t2_conv_len", 32'(conv_hi_a), 32'd2);
    check("t2_ovr", 32'(got_ovr_a), 32'd0);
    check("t2_idle_after", {30'd0, busy_a, sck_a}, 32'd0);

    // Reset for 3 clocks in the middle of SHIFT
    frame_a = mk_frame(14'h1234, 14'h0ABC);
    @(negedge clock);
    en_a = 1'b1;
    repeat (30) @(negedge clock);
    en_a = 1'b0;
    check("t1_busy_before", 32'(busy_a), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t1_ctrl_zero", {28'd0, ad_conv_a, sck_a, busy_a, dv_a}, 32'd0);
    check("t1_ch0_zero", 32'(ch0_a), 32'd0);
    check("t1_ch1_zero", 32'(ch1_a), 32'd0);
    dv_seen = 0;
    repeat (2) begin
      @(negedge clock);
      if (dv_a) dv_seen++;
    end
    reset = 1'b0;
    repeat (150) begin
      @(negedge clock);
      if (dv_a || busy_a) dv_seen++;
    end
    check("t1_no_activity", 32'(dv_seen), 32'd0);
    run_a(14'h0123, 14'h3ABC, 5, 0, 0, 200);
    check("t1_clean_latency", 32'(lat_a), 32'd140);
    check("t1_clean_ch0", 32'(got0_a), 32'h0123);
    check("t1_clean_ch1", 32'(got1_a), 32'h3ABC);

    // Level held high does not retrigger
    run_a(14'h3FFE, 14'h0002, 500, 0, 0, 650);
    check("t3_nvalid", 32'(nval_a), 32'd1);
    check("t3_ch0", 32'(got0_a), 32'h3FFE);
    check("t3_ch1", 32'(got1_a), 32'h0002);
    check("t3_hold_ch0", 32'(ch0_a), 32'h3FFE);

    // Second edge at T+50 while busy is dropped
    run_a(14'h0F0F, 14'h30F0, 10, 50, 60, 300);
    check("t4_nvalid", 32'(nval_a), 32'd1);
    check("t4_latency", 32'(lat_a), 32'd140);
    check("t4_ch0", 32'(got0_a), 32'h0F0F);

    // Full-scale detection
`ifdef ADC_OVR_DETECT_EN
    exp_ovr1 = 2'b01;
    exp_ovr2 = 2'b11;
`else
    exp_ovr1 = 2'b00;
    exp_ovr2 = 2'b00;
`endif
    run_a(14'h1FFF, 14'h0001, 5, 0, 0, 200);
    check("t5_ovr_a", 32'(got_ovr_a), 32'(exp_ovr1));
    check("t5_ovr_a_held", 32'(ovr_a), 32'(exp_ovr1));
    run_a(14'h2000, 14'h2000, 5, 0, 0, 200);
    check("t5_ovr_b", 32'(got_ovr_a), 32'(exp_ovr2));
    check("t5_ch0_negfs", 32'(got0_a), 32'h2000);

    // Fast instance: 35-clock enable pulses every 80 clocks, 1+1+68+1 = 71
    nval_b = 0;
    for (int k = 0; k < 3; k++) begin lat_b[k] = -1; b0[k] = 'x; b1[k] = 'x; end
    frame_b = mk_frame(14'h0AB1, 14'h3C00);
    @(negedge clock);
    en_b = 1'b1;
    for (int cyc = 1; cyc <= 240; cyc++) begin
      @(posedge clock);
      @(negedge clock);
      en_b = ((cyc % 80) < 35);
      if ((cyc % 80) == 0) frame_b = mk_frame(14'(14'h0AB1 + cyc), 14'(14'h3C00 - cyc));
      if (dv_b) begin
        if (nval_b < 3) begin
          lat_b[nval_b] = cyc + 1 - 80 * nval_b;
          b0[nval_b] = ch0_b;
          b1[nval_b] = ch1_b;
        end
        nval_b++;
      end
    end
    check("t6_nvalid", 32'(nval_b), 32'd3);
    check("t6_lat0", 32'(lat_b[0]), 32'd71);
    check("t6_lat1", 32'(lat_b[1]), 32'd71);
    check("t6_lat2", 32'(lat_b[2]), 32'd71);
    check("t6_ch0_f0", 32'(b0[0]), 32'h0AB1);
    check("t6_ch1_f0", 32'(b1[0]), 32'h3C00);
    check("t6_ch0_f1", 32'(b0[1]), 32'h0B01);
    check("t6_ch1_f1", 32'(b1[1]), 32'h3BB0);
    check("t6_ch0_f2", 32'(b0[2]), 32'h0B51);
    check("t6_ch1_f2", 32'(b1[2]), 32'h3B60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
